// File: rtl/spi_slave_if_if.sv
// SPI slave bus bundle: serial pins on the SPI side, command/read-data
// handshake on the RAM side. The slave modport is the front end's view;
// the master modport is the view of whatever drives SPI and the RAM model.
interface spi_slave_if_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = FRAME_W - 2
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port command RAM.
// Deserialises 10-bit MOSI frames {opcode[1:0], payload[7:0]} into rx_data
// with a one-cycle rx_valid strobe, and serialises the RAM read result back
// on MISO, MSB first, one bit per clk.
// Optional build macro SPI_ABORT_CNT_EN adds abort_cnt[7:0], a saturating
// count of frames aborted by SS_n going high before completion.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling frame bit 9, choosing the frame type
// WRITE     | receiving bits 8..0 of a write frame
// READ_ADD  | receiving bits 8..0 of a read-address frame, then arm flag
// READ_DATA | receive, RAM latency wait, tx_valid poll, 8-bit MISO shift
//
// Within READ_DATA the bit counter keeps counting past the receive phase so
// one counter sequences everything:
//   0..FRAME_W-2   receive bits 8..0
//   FRAME_W-1      rx_valid cycle
//   FRAME_W        RAM read-latency cycle
//   FRAME_W+1      polling tx_valid
//   FRAME_W+2..    one value per MISO bit being driven
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = FRAME_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_slave_if_if.slave      bus
`ifdef SPI_ABORT_CNT_EN
  ,
  output logic [7:0]         abort_cnt
`endif
);

  localparam int CNT_W = $clog2(2 * FRAME_W);

  localparam logic [CNT_W-1:0] CNT_RX_LAST  = CNT_W'(FRAME_W - 2);
  localparam logic [CNT_W-1:0] CNT_POLL     = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_OUT0     = CNT_W'(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_OUT_LAST = CNT_W'(FRAME_W + 1 + DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               rd_addr_flag_q, rd_addr_flag_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               abort_evt;
  logic [FRAME_W-1:0] rx_word;

  // Word as it stands once the current MOSI bit is shifted in.
  assign rx_word = {shift_q[FRAME_W-2:0], bus.MOSI};

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rd_addr_flag_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
    end
  end

  // Next-state and datapath decode; SS_n high outside IDLE aborts the frame.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rd_addr_flag_d = rd_addr_flag_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    abort_evt      = 1'b0;

    if (state_q != IDLE && bus.SS_n) begin
      state_d   = IDLE;
      cnt_d     = '0;
      shift_d   = '0;
      abort_evt = 1'b1;
      // An address is only consumed once its read-out has begun.
      if (state_q == READ_DATA && cnt_q >= CNT_OUT0) begin
        rd_addr_flag_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.SS_n) begin
            state_d = CHK_CMD;
            cnt_d   = '0;
          end
        end

        CHK_CMD: begin
          shift_d = rx_word;
          cnt_d   = '0;
          if (!bus.MOSI) begin
            state_d = WRITE;
          end else if (!rd_addr_flag_q) begin
            state_d = READ_ADD;
          end else begin
            state_d = READ_DATA;
          end
        end

        WRITE, READ_ADD: begin
          shift_d = rx_word;
          if (cnt_q == CNT_RX_LAST) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
            shift_d    = '0;
            if (state_q == READ_ADD) begin
              rd_addr_flag_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        READ_DATA: begin
          if (cnt_q <= CNT_RX_LAST) begin
            shift_d = rx_word;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_RX_LAST) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end
          end else if (cnt_q < CNT_POLL) begin
            // rx_valid cycle and RAM latency cycle: tx_valid is ignored here.
            cnt_d = cnt_q + 1'b1;
          end else if (cnt_q == CNT_POLL) begin
            if (bus.tx_valid) begin
              miso_d  = bus.tx_data[DATA_W-1];
              shift_d = {bus.tx_data[DATA_W-2:0], {(FRAME_W - DATA_W + 1){1'b0}}};
              cnt_d   = CNT_OUT0;
            end
          end else if (cnt_q == CNT_OUT_LAST) begin
            state_d        = IDLE;
            cnt_d          = '0;
            shift_d        = '0;
            rd_addr_flag_d = 1'b0;
          end else begin
            miso_d  = shift_q[FRAME_W-1];
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end
      endcase
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;

  // Saturating count of aborted frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_cnt_q <= 8'd0;
    end else if (abort_evt && abort_cnt_q != 8'hFF) begin
      abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  assign abort_cnt = abort_cnt_q;
`else
  logic abort_unused;
  assign abort_unused = abort_evt;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed test-plan frames followed by
// randomized frames, aborts and read-outs, checked against a frame-level model.
module tb_spi_slave_if;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  spi_slave_if_if bus ();

`ifdef SPI_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  spi_slave_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPI_ABORT_CNT_EN
    ,
    .abort_cnt (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model state.
  bit         m_flag;
  logic [9:0] m_rx;
  int         m_aborts;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_abort();
    if (m_aborts < 255) m_aborts++;
`ifdef SPI_ABORT_CNT_EN
    check_eq("abort_cnt", abort_cnt, m_aborts);
`endif
  endtask

  task automatic junk_tx();
    bus.tx_valid = 1'($urandom_range(0, 1));
    bus.tx_data  = 8'($urandom);
  endtask

  // One frame. abort_at: SS_n goes high in place of bit index abort_at
  // (0 = frame bit 9), -1 for none. rd_abort / rd_rst: abort or async reset
  // after that many MISO bits have been shown (1..7), -1 for none.
  task automatic run_frame(input logic [9:0] word, input int abort_at, input int rd_abort,
                           input int rd_rst, input int extra, input logic [7:0] d);
    bit is_rd_data;
    is_rd_data = word[9] && m_flag;
    bus.SS_n = 1'b0;
    junk_tx();
    tick();
    check_eq("start_rv", bus.rx_valid, 1'b0);
    check_eq("start_miso", bus.MISO, 1'b0);
    for (int i = 0; i < 10; i++) begin
      junk_tx();
      if (abort_at == i) begin
        bus.SS_n = 1'b1;
        tick();
        check_eq("abort_rv", bus.rx_valid, 1'b0);
        check_eq("abort_miso", bus.MISO, 1'b0);
        check_eq("abort_rx_hold", bus.rx_data, m_rx);
        count_abort();
        return;
      end
      bus.MOSI = word[9 - i];
      tick();
      if (i < 9) check_eq("rx_rv_low", bus.rx_valid, 1'b0);
      check_eq("rx_miso", bus.MISO, 1'b0);
    end
    check_eq("rv_strobe", bus.rx_valid, 1'b1);
    check_eq("rx_data", bus.rx_data, word);
    m_rx = word;
    if (!word[9]) return;
    if (!is_rd_data) begin
      m_flag = 1'b1;
      return;
    end
    // rx_valid cycle and latency cycle: tx_valid here must be ignored.
    junk_tx();
    tick();
    check_eq("rv_single", bus.rx_valid, 1'b0);
    check_eq("lat_miso", bus.MISO, 1'b0);
    junk_tx();
    tick();
    check_eq("lat_miso", bus.MISO, 1'b0);
    for (int e = 0; e < extra; e++) begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      tick();
      check_eq("poll_miso", bus.MISO, 1'b0);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    tick();
    for (int k = 0; k < 8; k++) begin
      junk_tx();
      check_eq("miso_bit", bus.MISO, d[7 - k]);
      if (k == 7) break;
      if (rd_abort == k + 1) begin
        bus.SS_n = 1'b1;
        tick();
        check_eq("rdab_miso", bus.MISO, 1'b0);
        m_flag = 1'b0;
        count_abort();
        return;
      end
      if (rd_rst == k + 1) begin
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_miso", bus.MISO, 1'b0);
        check_eq("arst_rv", bus.rx_valid, 1'b0);
        check_eq("arst_rx", bus.rx_data, 10'h000);
        m_flag   = 1'b0;
        m_rx     = 10'h000;
        m_aborts = 0;
`ifdef SPI_ABORT_CNT_EN
        check_eq("arst_abcnt", abort_cnt, 8'd0);
`endif
        bus.SS_n = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      tick();
    end
    tick();
    check_eq("end_miso", bus.MISO, 1'b0);
    m_flag = 1'b0;
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    m_flag   = 1'b0;
    m_rx     = 10'h000;
    m_aborts = 0;
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #1;
    check_eq("rst_miso", bus.MISO, 1'b0);
    check_eq("rst_rv", bus.rx_valid, 1'b0);
    check_eq("rst_rx", bus.rx_data, 10'h000);
`ifdef SPI_ABORT_CNT_EN
    check_eq("rst_abcnt", abort_cnt, 8'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Test-plan sequence.
    run_frame(10'h005, -1, -1, -1, 0, 8'h00);
    run_frame(10'h1A5, -1, -1, -1, 0, 8'h00);
    bus.SS_n = 1'b1;
    tick();
    run_frame(10'h205, -1, -1, -1, 0, 8'h00);
    run_frame({2'b11, 8'($urandom)}, -1, -1, -1, 0, 8'hA5);
    run_frame({2'b00, 8'($urandom)}, 6, -1, -1, 0, 8'h00);
    bus.SS_n = 1'b1;
    tick();
    run_frame(10'h233, -1, -1, -1, 0, 8'h00);
    run_frame(10'h3C4, -1, -1, -1, 5, 8'h6E);
    run_frame(10'h2F0, -1, -1, -1, 0, 8'h00);
    run_frame(10'h30F, -1, -1, 4, 1, 8'hC3);
    // After reset the flag is clear: this 10x frame is an address frame.
    run_frame(10'h2AA, -1, -1, -1, 0, 8'h00);
    run_frame(10'h355, -1, -1, -1, 2, 8'h5A);

    // Randomized frames.
    for (int n = 0; n < 200; n++) begin
      logic [9:0] w;
      int ab, rab, ex;
      w   = 10'($urandom);
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      rab = (ab < 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : -1;
      ex  = int'($urandom_range(0, 3));
      run_frame(w, ab, rab, -1, ex, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        bus.SS_n = 1'b1;
        tick();
        check_eq("gap_rv", bus.rx_valid, 1'b0);
      end
    end

`ifdef SPI_ABORT_CNT_EN
    // Drive the abort counter into saturation.
    for (int n = 0; n < 270; n++) begin
      bus.SS_n = 1'b0;
      tick();
      bus.SS_n = 1'b1;
      tick();
      count_abort();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port command RAM.
- Deserialises 10-bit MOSI frames into a parallel command word on rx_data/rx_valid.
- Serialises the RAM read result back on MISO.
- SPI bit timing is one bit per clk cycle, qualified by SS_n; clk is the SPI clock.

Parameters:
- FRAME_W, 10, command frame width: 2-bit opcode plus 8-bit payload.
- DATA_W, 8, read-data width shifted out on MISO; always FRAME_W-2.

Ports:
- clk  input  1  system/SPI clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- SS_n  input  1  slave select, active low, sampled on clk
- MOSI  input  1  serial data in, MSB first, sampled on clk
- MISO  output  1  serial data out, MSB first
- rx_data  output  FRAME_W  parallel command word to RAM {opcode[1:0], payload[7:0]}
- rx_valid  output  1  one-cycle strobe, rx_data valid
- tx_data  input  DATA_W  read data from RAM
- tx_valid  input  1  RAM read data valid

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - On rst=1: state=IDLE, bit counter=0, shift reg=0, rd_addr_flag=0, rx_data=0, rx_valid=0, MISO=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; else stay.
- CHK_CMD:
  - Samples frame bit 9 from MOSI into the shift register.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_flag=0 -> READ_ADD.
  - MOSI=1 and rd_addr_flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift MOSI in for 9 more cycles (bits 8..0).
  - The cycle after bit 0 is sampled: rx_data <= full 10-bit word, rx_valid=1 for exactly that one cycle.
- Completion in WRITE or READ_ADD:
  - Return to IDLE after the rx_valid cycle.
  - READ_ADD additionally sets rd_addr_flag=1.
- Completion in READ_DATA:
  - After rx_valid, wait one cycle (RAM read latency).
  - From the following cycle, sample tx_valid each cycle.
  - On first tx_valid=1: latch tx_data and drive its MSB on MISO the next cycle.
  - Shift remaining bits out, one per cycle: 8 MISO cycles total.
  - Then clear rd_addr_flag and go to IDLE.
- MISO is 0 whenever not shifting read data.
- SS_n=1 in any non-IDLE state (abort):
  - Next state IDLE; counter and shift reg cleared.
  - No rx_valid issued for the partial frame.
  - rd_addr_flag unchanged unless the READ_DATA read-out had started; if it had, the flag is cleared.
- SS_n=1 in the same cycle the 10th bit would be sampled: frame is aborted, no rx_valid.
- tx_valid outside the READ_DATA wait phase is ignored.
- rx_data holds its last value between strobes.
- Back-to-back frames:
  - SS_n may stay low.
  - After returning to IDLE, SS_n=0 re-enters CHK_CMD on the next cycle.
  - This costs one dead cycle per frame, which the master must insert.
- Reset mid-frame: immediate return to reset values; no strobe.

Optional Feature:
- Macro: SPI_ABORT_CNT_EN.
- Defined:
  - Adds output port abort_cnt [7:0].
  - abort_cnt is a saturating count of frames aborted by SS_n=1 before completion.
  - Increments once per abort and saturates at 255.
  - Reset value 0.
- Undefined: no port and no counter; abort behaviour is otherwise identical.

Test Plan:
- Write address: rst pulse, SS_n=0, MOSI 00_0000_0101 -> one rx_valid with rx_data=10'h005, rd_addr_flag unchanged, MISO=0 throughout.
- Write data: frame 01_1010_0101 -> rx_data=10'h1A5, single-cycle rx_valid, FSM back to IDLE.
- Read sequence:
  - Frame 10_0000_0101 -> rx_data=10'h205, rd_addr_flag=1.
  - Frame 11_xxxx_xxxx -> rx_data[9:8]=2'b11.
  - Model drives tx_data=8'hA5 with tx_valid two cycles after rx_valid -> MISO serialises 1,0,1,0,0,1,0,1; rd_addr_flag=0 afterwards.
- Abort: raise SS_n after 6 bits of a WRITE frame -> no rx_valid, FSM in IDLE next cycle; with SPI_ABORT_CNT_EN, abort_cnt 0->1.
- Delayed tx_valid: hold tx_valid=0 for 5 cycles after rx_valid in READ_DATA -> MISO stays 0 until tx_valid=1, then 8 correct bits are shifted out.
- Async reset during READ_DATA shift-out -> MISO=0, rx_valid=0, rd_addr_flag=0 immediately, without waiting for clk.
